// File: rtl/mem_arbiter.sv
// Shares one 8-bit SRAM port between the CPU core and a DMA requester.
// Inserts WAIT wait states per access and stalls the core through core_locked.
module mem_arbiter #(
    parameter int unsigned WAIT       = 0,
    parameter int unsigned CORE_SLOTS = 1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        pll_locked,
    input  logic [19:0] core_address,
    input  logic [7:0]  core_out,
    input  logic        core_we,
    output logic [7:0]  core_in,
    output logic        core_locked,
    input  logic        dma_req,
    input  logic [19:0] dma_address,
    input  logic [7:0]  dma_wdata,
    input  logic        dma_we,
    output logic        dma_ack,
    output logic [7:0]  dma_rdata,
    output logic [19:0] mem_address,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    input  logic [7:0]  mem_rdata
);

    typedef enum logic [0:0] {StCore, StDma} state_e;

    localparam logic [3:0] WaitCount = 4'(WAIT);
    localparam logic [3:0] SlotCount = 4'(CORE_SLOTS);

    state_e      st_q, st_d;
    logic [3:0]  wcnt_q, wcnt_d;
    logic [3:0]  credit_q, credit_d;
    logic        dma_ack_q, dma_ack_d;
    logic [7:0]  dma_rdata_q, dma_rdata_d;
    logic        last;

    // Final cycle of the current access; never true while frozen.
    assign last = (wcnt_q == WaitCount) && pll_locked;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            st_q        <= StCore;
            wcnt_q      <= 4'd0;
            credit_q    <= 4'd0;
            dma_ack_q   <= 1'b0;
            dma_rdata_q <= 8'h00;
        end else begin
            st_q        <= st_d;
            wcnt_q      <= wcnt_d;
            credit_q    <= credit_d;
            dma_ack_q   <= dma_ack_d;
            dma_rdata_q <= dma_rdata_d;
        end
    end

    always_comb begin
        st_d        = st_q;
        wcnt_d      = wcnt_q;
        credit_d    = credit_q;
        dma_ack_d   = dma_ack_q;
        dma_rdata_d = dma_rdata_q;
        if (pll_locked) begin
            dma_ack_d = 1'b0;
            if (!last) begin
                wcnt_d = wcnt_q + 4'd1;
            end else begin
                wcnt_d = 4'd0;
                unique case (st_q)
                    StCore: begin
                        // Credit guarantees the core its slots after each DMA grant.
                        if (credit_q != 4'd0) begin
                            credit_d = credit_q - 4'd1;
                        end else if (dma_req) begin
                            st_d = StDma;
                        end
                    end
                    StDma: begin
                        dma_ack_d   = 1'b1;
                        dma_rdata_d = mem_rdata;
                        credit_d    = SlotCount;
                        st_d        = StCore;
                    end
                    default: st_d = StCore;
                endcase
            end
        end
    end

    always_comb begin
        core_in     = mem_rdata;
        core_locked = (st_q == StCore) && last;
        dma_ack     = dma_ack_q;
        dma_rdata   = dma_rdata_q;
        if (st_q == StDma) begin
            mem_address = dma_address;
            mem_wdata   = dma_wdata;
            mem_we      = last && dma_we;
        end else begin
            mem_address = core_address;
            mem_wdata   = core_out;
            mem_we      = last && core_we;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: five instances with different WAIT/CORE_SLOTS share stimulus.
module tb_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        pll_locked;
    logic [19:0] core_address;
    logic [7:0]  core_out;
    logic        core_we;
    logic        dma_req;
    logic [19:0] dma_address;
    logic [7:0]  dma_wdata;
    logic        dma_we;
    logic [7:0]  mem_rdata;

    // Instance index: 0 W0/S1, 1 W2/S1, 2 W0/S2, 3 W1/S1, 4 W3/S1
    logic [7:0]  core_in     [5];
    logic        core_locked [5];
    logic        dma_ack     [5];
    logic [7:0]  dma_rdata   [5];
    logic [19:0] mem_address [5];
    logic [7:0]  mem_wdata   [5];
    logic        mem_we      [5];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    mem_arbiter #(.WAIT(0), .CORE_SLOTS(1)) u0 (
        .clock(clock), .reset_n(reset_n), .pll_locked(pll_locked),
        .core_address(core_address), .core_out(core_out), .core_we(core_we),
        .core_in(core_in[0]), .core_locked(core_locked[0]), .dma_req(dma_req),
        .dma_address(dma_address), .dma_wdata(dma_wdata), .dma_we(dma_we),
        .dma_ack(dma_ack[0]), .dma_rdata(dma_rdata[0]), .mem_address(mem_address[0]),
        .mem_wdata(mem_wdata[0]), .mem_we(mem_we[0]), .mem_rdata(mem_rdata)
    );
    mem_arbiter #(.WAIT(2), .CORE_SLOTS(1)) u2 (
        .clock(clock), .reset_n(reset_n), .pll_locked(pll_locked),
        .core_address(core_address), .core_out(core_out), .core_we(core_we),
        .core_in(core_in[1]), .core_locked(core_locked[1]), .dma_req(dma_req),
        .dma_address(dma_address), .dma_wdata(dma_wdata), .dma_we(dma_we),
        .dma_ack(dma_ack[1]), .dma_rdata(dma_rdata[1]), .mem_address(mem_address[1]),
        .mem_wdata(mem_wdata[1]), .mem_we(mem_we[1]), .mem_rdata(mem_rdata)
    );
    mem_arbiter #(.WAIT(0), .CORE_SLOTS(2)) u4 (
        .clock(clock), .reset_n(reset_n), .pll_locked(pll_locked),
        .core_address(core_address), .core_out(core_out), .core_we(core_we),
        .core_in(core_in[2]), .core_locked(core_locked[2]), .dma_req(dma_req),
        .dma_address(dma_address), .dma_wdata(dma_wdata), .dma_we(dma_we),
        .dma_ack(dma_ack[2]), .dma_rdata(dma_rdata[2]), .mem_address(mem_address[2]),
        .mem_wdata(mem_wdata[2]), .mem_we(mem_we[2]), .mem_rdata(mem_rdata)
    );
    mem_arbiter #(.WAIT(1), .CORE_SLOTS(1)) u5 (
        .clock(clock), .reset_n(reset_n), .pll_locked(pll_locked),
        .core_address(core_address), .core_out(core_out), .core_we(core_we),
        .core_in(core_in[3]), .core_locked(core_locked[3]), .dma_req(dma_req),
        .dma_address(dma_address), .dma_wdata(dma_wdata), .dma_we(dma_we),
        .dma_ack(dma_ack[3]), .dma_rdata(dma_rdata[3]), .mem_address(mem_address[3]),
        .mem_wdata(mem_wdata[3]), .mem_we(mem_we[3]), .mem_rdata(mem_rdata)
    );
    mem_arbiter #(.WAIT(3), .CORE_SLOTS(1)) u6 (
        .clock(clock), .reset_n(reset_n), .pll_locked(pll_locked),
        .core_address(core_address), .core_out(core_out), .core_we(core_we),
        .core_in(core_in[4]), .core_locked(core_locked[4]), .dma_req(dma_req),
        .dma_address(dma_address), .dma_wdata(dma_wdata), .dma_we(dma_we),
        .dma_ack(dma_ack[4]), .dma_rdata(dma_rdata[4]), .mem_address(mem_address[4]),
        .mem_wdata(mem_wdata[4]), .mem_we(mem_we[4]), .mem_rdata(mem_rdata)
    );

    typedef struct {
        logic        pll;
        logic        req;
        logic        dwe;
        logic        cwe;
        logic [7:0]  rdata;
        logic        e_lock;
        logic        e_we;
        logic        e_ack;
        logic [19:0] e_addr;
        logic [7:0]  e_wdata;
        logic [7:0]  e_drd;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Leaves the bench at a negedge with reset released; cycle 0 starts here.
    task automatic do_reset();
        @(negedge clock);
        reset_n      = 1'b0;
        pll_locked   = 1'b1;
        core_address = 20'h0FFF0;
        core_out     = 8'h5A;
        core_we      = 1'b0;
        dma_req      = 1'b0;
        dma_address  = 20'h12345;
        dma_wdata    = 8'h3C;
        dma_we       = 1'b0;
        mem_rdata    = 8'hA5;
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 20'h0FFF0, 8'h5A, 8'h00};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 20'h0FFF0, 8'h5A, 8'h00};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0, 20'h0FFF0, 8'h5A, 8'h00};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 20'h12345, 8'h3C, 8'h00};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, 20'h0FFF0, 8'h5A, 8'hA5};
        vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h77, 1'b1, 1'b0, 1'b0, 20'h0FFF0, 8'h5A, 8'hA5};
        vecs[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h77, 1'b0, 1'b1, 1'b0, 20'h12345, 8'h3C, 8'hA5};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h77, 1'b0, 1'b0, 1'b1, 20'h0FFF0, 8'h5A, 8'h77};
        vecs[8] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h77, 1'b1, 1'b1, 1'b1, 20'h0FFF0, 8'h5A, 8'h77};
        vecs[9] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h77, 1'b1, 1'b0, 1'b0, 20'h0FFF0, 8'h5A, 8'h77};

        // Reset state, checked while reset_n is still low
        reset_n = 1'b0;
        pll_locked = 1'b1;
        core_address = 20'h0FFF0;
        core_out = 8'h5A;
        core_we = 1'b0;
        dma_req = 1'b0;
        dma_address = 20'h12345;
        dma_wdata = 8'h3C;
        dma_we = 1'b0;
        mem_rdata = 8'hA5;
        #3;
        chk("rst_locked_w0", 32'(core_locked[0]), 32'd1);
        chk("rst_locked_w3", 32'(core_locked[4]), 32'd0);
        chk("rst_ack", 32'(dma_ack[0]), 32'd0);
        chk("rst_rdata", 32'(dma_rdata[0]), 32'h00);
        chk("rst_addr", 32'(mem_address[0]), 32'h0FFF0);

        // T1/T3 plus credit and freeze behaviour on the WAIT=0 instance
        do_reset();
        for (int i = 0; i < 10; i++) begin
            pll_locked = vecs[i].pll;
            dma_req    = vecs[i].req;
            dma_we     = vecs[i].dwe;
            core_we    = vecs[i].cwe;
            mem_rdata  = vecs[i].rdata;
            #1;
            chk($sformatf("v%0d_locked", i), 32'(core_locked[0]), 32'(vecs[i].e_lock));
            chk($sformatf("v%0d_we", i), 32'(mem_we[0]), 32'(vecs[i].e_we));
            chk($sformatf("v%0d_ack", i), 32'(dma_ack[0]), 32'(vecs[i].e_ack));
            chk($sformatf("v%0d_addr", i), 32'(mem_address[0]), 32'(vecs[i].e_addr));
            chk($sformatf("v%0d_wdata", i), 32'(mem_wdata[0]), 32'(vecs[i].e_wdata));
            chk($sformatf("v%0d_drd", i), 32'(dma_rdata[0]), 32'(vecs[i].e_drd));
            chk($sformatf("v%0d_cin", i), 32'(core_in[0]), 32'(vecs[i].rdata));
            @(negedge clock);
        end

        // T2: WAIT=2 core writes, strobe and run-enable on every third cycle
        do_reset();
        core_we = 1'b1;
        for (int i = 0; i < 9; i++) begin
            #1;
            chk($sformatf("t2_locked%0d", i), 32'(core_locked[1]), 32'(i % 3 == 2));
            chk($sformatf("t2_we%0d", i), 32'(mem_we[1]), 32'(i % 3 == 2));
            chk($sformatf("t2_addr%0d", i), 32'(mem_address[1]), 32'h0FFF0);
            @(negedge clock);
        end

        // T4: CORE_SLOTS=2 with a permanently pending DMA request
        do_reset();
        dma_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk($sformatf("t4_locked%0d", i), 32'(core_locked[2]),
                32'(!(i == 1 || i == 5 || i == 9)));
            chk($sformatf("t4_ack%0d", i), 32'(dma_ack[2]),
                32'(i == 2 || i == 6));
            @(negedge clock);
        end

        // T5: WAIT=1 DMA write frozen for 3 cycles at the start of the DMA access
        do_reset();
        dma_address = 20'h00400;
        dma_wdata   = 8'h3C;
        dma_we      = 1'b1;
        for (int i = 0; i < 8; i++) begin
            pll_locked = !(i >= 2 && i <= 4);
            dma_req    = (i < 7);
            #1;
            chk($sformatf("t5_we%0d", i), 32'(mem_we[3]), 32'(i == 6));
            chk($sformatf("t5_ack%0d", i), 32'(dma_ack[3]), 32'(i == 7));
            chk($sformatf("t5_locked%0d", i), 32'(core_locked[3]), 32'(i == 1));
            if (i == 6) begin
                chk("t5_addr", 32'(mem_address[3]), 32'h00400);
                chk("t5_wdata", 32'(mem_wdata[3]), 32'h3C);
            end
            @(negedge clock);
        end
        #1;
        chk("t5_rdata", 32'(dma_rdata[3]), 32'hA5);

        // T6: WAIT=3, reset pulsed during the third DMA wait cycle
        do_reset();
        dma_req = 1'b1;
        dma_we  = 1'b1;
        for (int i = 0; i < 7; i++) begin
            #1;
            chk($sformatf("t6_locked%0d", i), 32'(core_locked[4]), 32'(i == 3));
            chk($sformatf("t6_we%0d", i), 32'(mem_we[4]), 32'd0);
            if (i == 6) chk("t6_dma_addr", 32'(mem_address[4]), 32'h12345);
            if (i < 6) @(negedge clock);
        end
        #1;
        reset_n = 1'b0;
        dma_req = 1'b0;
        #1;
        chk("t6_rst_addr", 32'(mem_address[4]), 32'h0FFF0);
        chk("t6_rst_ack", 32'(dma_ack[4]), 32'd0);
        chk("t6_rst_rdata", 32'(dma_rdata[4]), 32'h00);
        chk("t6_rst_we", 32'(mem_we[4]), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("t6_post_ack%0d", i), 32'(dma_ack[4]), 32'd0);
            chk($sformatf("t6_post_we%0d", i), 32'(mem_we[4]), 32'd0);
            @(negedge clock);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
